dice_display: RTL
=================

# dice_display

Downstream consumer of the electronic-dice FSM's `throw[2:0]` output.
- While the button is held, shows the rolling value on a 7-pip LED face, blinking.
- On release, captures the settled throw and holds it as the result.
- Pulses a one-cycle valid strobe and maintains roll statistics: count, repeated-value flag, sticky illegal-value error.
- Sits between the dice FSM and the board LEDs / status logic, sharing its clock, reset and button input.

## Interface
- `BLINK_CYCLES`, default 8: cycles per blink half-period while rolling; legal range 2..255.
- `clk`  in  1  system clock; all registers on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `button`  in  1  roll button, same signal driving the dice FSM, already synchronous to `clk`.
- `throw`  in  3  current dice value from the dice FSM, legal range 1..6.
- `leds`  out  7  pip drive, 1 = lit; bit map: [0] TL, [1] TR, [2] ML, [3] C, [4] MR, [5] BL, [6] BR.
- `result`  out  3  last captured throw; 0 = no roll yet.
- `result_valid`  out  1  one-cycle pulse, coincident with the first cycle of a new `result`.
- `roll_count`  out  8  completed rolls, saturating at 255.
- `repeat_flag`  out  1  last roll equalled the previous roll.
- `error`  out  1  sticky; set when an illegal throw (0 or 7) is captured.

## Operation
- Button edge detection:
  - `btn_q` registers `button` each cycle.
  - rise = `button & ~btn_q`; fall = `~button & btn_q`.
- States: SHOW, ROLLING, SETTLE. Reset enters SHOW.
- SHOW:
  - `leds` = pattern(`result`).
  - rise → ROLLING.
- ROLLING:
  - `leds` = `phase` ? pattern(`throw`) : 0.
  - `blink_cnt` counts 0..BLINK_CYCLES-1; at wrap `phase` toggles and `blink_cnt` returns to 0.
  - Entering ROLLING loads `blink_cnt` = 0 and `phase` = 1.
  - fall → SETTLE.
  - rise is impossible in this state and is ignored.
- SETTLE: lasts exactly one cycle, then SHOW unconditionally. On its closing edge:
  - `result` ← `throw`.
  - `result_valid` ← 1.
  - `roll_count` ← `roll_count` + 1 unless already 255.
  - `repeat_flag` ← (`throw` == old `result`) && (old `result` != 0).
  - `error` ← `error` | (`throw` == 0 | `throw` == 7).
- Rationale for SETTLE: the dice FSM stops advancing on the edge where `button` is first seen low, so `throw` is stable in the SETTLE cycle.
- Pip patterns [6:0]; every other value gives 0000000:
  - 1: 0001000
  - 2: 1000001
  - 3: 1001001
  - 4: 1100011
  - 5: 1101011
  - 6: 1110111
- `leds` is registered: it reflects the state/values of the previous cycle, i.e. one cycle of latency.
- `result_valid` is 0 in every cycle except the one following SETTLE.
- An illegal captured throw still updates `result` and `roll_count`. `leds` then show 0 in SHOW.

## Timing
- Reset values: state SHOW, `btn_q` 0, `leds` 0, `result` 0, `result_valid` 0, `roll_count` 0, `repeat_flag` 0, `error` 0, `blink_cnt` 0, `phase` 0.
- Press: `button` is first high in cycle k. The state is ROLLING from edge k+1. `leds` first show the blinking pattern after edge k+2.
- Release: `button` is first low in cycle r. The state is SETTLE from edge r+1. `result` and `result_valid` update at edge r+2. `result_valid` falls at edge r+3.
- A one-cycle press (high in cycle k only) is a legal roll: ROLLING for one cycle, SETTLE, then capture.
- A new press in the first SHOW cycle after SETTLE is accepted normally. `result_valid` still pulses for exactly one cycle.
- Reset asserted mid-roll or during SETTLE: all outputs return to reset values immediately (asynchronously); no capture occurs.
- `roll_count` holds at 255; `repeat_flag` and capture continue to work at saturation.

## Test plan
- Reset, no press: `leds`=0, `result`=0, `result_valid`=0, `roll_count`=0, `error`=0 → all hold for 20 cycles.
- Hold `button` with `throw` driven 3 for 40 cycles, BLINK_CYCLES=8: `leds` alternate 1001001 / 0000000 every 8 cycles, starting lit. Release → two edges later `result`=3, one-cycle `result_valid`, `roll_count`=1, `leds`=1001001 steady.
- Two consecutive rolls ending on 5 each: after the second, `repeat_flag`=1 and `roll_count`=2. A third roll ending on 2: `repeat_flag`=0, `leds`=1000001.
- Roll ending with `throw`=7 forced: `result`=7, `error`=1, `leds`=0000000. A following legal roll to 4 leaves `error`=1 and gives `leds`=1100011.
- Assert `rst` during ROLLING, then during SETTLE: no `result_valid` pulse, all outputs at reset values, SHOW on release of reset.
- 260 one-cycle presses ending on 6: `roll_count` saturates at 255, `result`=6, `repeat_flag`=1 on every roll after the first.

Source files
------------

// File: rtl/dice_display.sv
// LED face and roll bookkeeping for the electronic dice: blinks the rolling value
// while the button is held, then captures and holds the settled throw.
module dice_display #(
  parameter int unsigned BLINK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] throw,
  output logic [6:0] leds,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [7:0] roll_count,
  output logic       repeat_flag,
  output logic       error
);

  typedef enum logic [1:0] {
    SHOW,
    ROLLING,
    SETTLE
  } state_e;

  localparam logic [7:0] BlinkLast = 8'(BLINK_CYCLES - 1);

  state_e     state_q, state_d;
  logic       btn_q;
  logic       rise, fall;
  logic [7:0] blinkCnt_q, blinkCnt_d;
  logic       phase_q, phase_d;
  logic [6:0] leds_q, leds_d;
  logic [2:0] result_q, result_d;
  logic       resultValid_q, resultValid_d;
  logic [7:0] rollCount_q, rollCount_d;
  logic       repeatFlag_q, repeatFlag_d;
  logic       error_q, error_d;

  // Pip map [6:0] = BR BL MR C ML TR TL; anything outside 1..6 shows a blank face.
  function automatic logic [6:0] pipPattern(input logic [2:0] value);
    logic [6:0] pips;
    case (value)
      3'd1:    pips = 7'b0001000;
      3'd2:    pips = 7'b1000001;
      3'd3:    pips = 7'b1001001;
      3'd4:    pips = 7'b1100011;
      3'd5:    pips = 7'b1101011;
      3'd6:    pips = 7'b1110111;
      default: pips = 7'b0000000;
    endcase
    return pips;
  endfunction

  assign rise = button & ~btn_q;
  assign fall = ~button & btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SHOW;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW:    if (rise) state_d = ROLLING;
      ROLLING: if (fall) state_d = SETTLE;
      SETTLE:  state_d = SHOW;
      default: state_d = SHOW;
    endcase
  end

  always_comb begin
    blinkCnt_d    = blinkCnt_q;
    phase_d       = phase_q;
    leds_d        = 7'b0000000;
    result_d      = result_q;
    resultValid_d = 1'b0;
    rollCount_d   = rollCount_q;
    repeatFlag_d  = repeatFlag_q;
    error_d       = error_q;
    case (state_q)
      SHOW: begin
        leds_d = pipPattern(result_q);
        if (rise) begin
          blinkCnt_d = 8'd0;
          phase_d    = 1'b1;
        end
      end
      ROLLING: begin
        leds_d = phase_q ? pipPattern(throw) : 7'b0000000;
        if (blinkCnt_q == BlinkLast) begin
          blinkCnt_d = 8'd0;
          phase_d    = ~phase_q;
        end else begin
          blinkCnt_d = blinkCnt_q + 8'd1;
        end
      end
      SETTLE: begin
        // The dice FSM has stopped by now, so throw is the settled value.
        leds_d        = pipPattern(result_q);
        result_d      = throw;
        resultValid_d = 1'b1;
        if (rollCount_q != 8'hFF) rollCount_d = rollCount_q + 8'd1;
        repeatFlag_d  = (throw == result_q) && (result_q != 3'd0);
        error_d       = error_q | (throw == 3'd0) | (throw == 3'd7);
      end
      default: leds_d = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q         <= 1'b0;
      blinkCnt_q    <= 8'd0;
      phase_q       <= 1'b0;
      leds_q        <= 7'b0000000;
      result_q      <= 3'd0;
      resultValid_q <= 1'b0;
      rollCount_q   <= 8'd0;
      repeatFlag_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      btn_q         <= button;
      blinkCnt_q    <= blinkCnt_d;
      phase_q       <= phase_d;
      leds_q        <= leds_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      rollCount_q   <= rollCount_d;
      repeatFlag_q  <= repeatFlag_d;
      error_q       <= error_d;
    end
  end

  assign leds         = leds_q;
  assign result       = result_q;
  assign result_valid = resultValid_q;
  assign roll_count   = rollCount_q;
  assign repeat_flag  = repeatFlag_q;
  assign error        = error_q;

endmodule
